overlay_motion_sched: RTL

- Per-frame scheduler that moves the "TT08" text overlay around the 640x480 VGA screen, bouncing it off the edges like a screensaver.
- It drives the tile-coordinate origin (8x8-pixel tiles) that the text overlay lookup subtracts from x[9:3]/y[8:3].
- On a corner hit it freezes the text and blinks it before resuming.
- All updates land only in vertical blank, so a frame never tears.

---
 rtl/overlay_motion_sched_if.sv | 22 ++
 rtl/overlay_motion_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/overlay_motion_sched_if.sv
// Frame-tick control in, overlay origin/visibility state out, for overlay_motion_sched.
interface overlay_motion_sched_if;
    logic       frame_tick;
    logic       run;
    logic [6:0] origin_x;
    logic [5:0] origin_y;
    logic       dir_x;
    logic       dir_y;
    logic       text_visible;
    logic       corner_hit;
    logic [7:0] bounce_count;

    modport master (
        output frame_tick, run,
        input  origin_x, origin_y, dir_x, dir_y, text_visible, corner_hit, bounce_count
    );

    modport slave (
        input  frame_tick, run,
        output origin_x, origin_y, dir_x, dir_y, text_visible, corner_hit, bounce_count
    );
endinterface

// File: rtl/overlay_motion_sched.sv
// Vblank-stepped bouncing origin for the "TT08" tile overlay, with a blink pause on corner hits.
// Optional OVERLAY_LFSR_EN: pseudo-random relocation of the origin when the blink pause ends.
module overlay_motion_sched #(
    parameter int TILE_W_MAX   = 80,
    parameter int TILE_H_MAX   = 60,
    parameter int BOX_W        = 23,
    parameter int BOX_H        = 9,
    parameter int X_INIT       = 30,
    parameter int Y_INIT       = 24,
    parameter int FRAME_DIV    = 2,
    parameter int BLINK_PERIOD = 4,
    parameter int PAUSE_FRAMES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    overlay_motion_sched_if.slave  bus
);
    localparam int X_MAX = TILE_W_MAX - BOX_W;
    localparam int Y_MAX = TILE_H_MAX - BOX_H;
    localparam int DW    = $clog2(FRAME_DIV + 1);
    localparam int BW    = $clog2(BLINK_PERIOD + 1);
    localparam int PW    = $clog2(PAUSE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, MOVE, BLINK} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [PW-1:0] pause_q, pause_d;
    logic [6:0]    x_q, x_d;
    logic [5:0]    y_q, y_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic          vis_q, vis_d, ch_q, ch_d;
    logic [7:0]    bc_q, bc_d;
    logic          x_bnc, y_bnc;

    // A bounce flips direction; the step then goes one tile in the new direction.
    assign x_bnc = dx_q ? (x_q >= 7'(X_MAX)) : (x_q == 7'd0);
    assign y_bnc = dy_q ? (y_q >= 6'(Y_MAX)) : (y_q == 6'd0);

`ifdef OVERLAY_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              lfsr_q <= 8'hA5;
        else if (bus.frame_tick) lfsr_q <= lfsr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        blink_d = blink_q;
        pause_d = pause_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        vis_d   = vis_q;
        bc_d    = bc_q;
        ch_d    = 1'b0;
        if (bus.frame_tick) begin
            if (!bus.run) begin
                if (state_q != IDLE) begin
                    state_d = IDLE;
                    vis_d   = 1'b1;
                    div_d   = '0;
                    blink_d = '0;
                    pause_d = '0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_d = MOVE;
                        div_d   = '0;
                    end
                    MOVE: begin
                        if (div_q == DW'(FRAME_DIV - 1)) begin
                            div_d = '0;
                            dx_d  = dx_q ^ x_bnc;
                            dy_d  = dy_q ^ y_bnc;
                            x_d   = (dx_q ^ x_bnc) ? x_q + 7'd1 : x_q - 7'd1;
                            y_d   = (dy_q ^ y_bnc) ? y_q + 6'd1 : y_q - 6'd1;
                            if ((x_bnc || y_bnc) && bc_q != 8'hFF) bc_d = bc_q + 8'd1;
                            if (x_bnc && y_bnc) begin
                                ch_d    = 1'b1;
                                state_d = BLINK;
                                vis_d   = 1'b0;
                                blink_d = '0;
                                pause_d = '0;
                            end
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                    BLINK: begin
                        if (pause_q == PW'(PAUSE_FRAMES - 1)) begin
                            state_d = MOVE;
                            vis_d   = 1'b1;
                            div_d   = '0;
                            blink_d = '0;
                            pause_d = '0;
`ifdef OVERLAY_LFSR_EN
                            x_d = ({1'b0, lfsr_d[5:0]} > 7'(X_MAX)) ? 7'(X_MAX) : {1'b0, lfsr_d[5:0]};
                            y_d = (lfsr_d[7:2] > 6'(Y_MAX)) ? 6'(Y_MAX) : lfsr_d[7:2];
`endif
                        end else begin
                            pause_d = pause_q + 1'b1;
                            if (blink_q == BW'(BLINK_PERIOD - 1)) begin
                                vis_d   = ~vis_q;
                                blink_d = '0;
                            end else begin
                                blink_d = blink_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            blink_q <= '0;
            pause_q <= '0;
            x_q     <= 7'(X_INIT);
            y_q     <= 6'(Y_INIT);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            vis_q   <= 1'b1;
            ch_q    <= 1'b0;
            bc_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            blink_q <= blink_d;
            pause_q <= pause_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            vis_q   <= vis_d;
            ch_q    <= ch_d;
            bc_q    <= bc_d;
        end
    end

    assign bus.origin_x     = x_q;
    assign bus.origin_y     = y_q;
    assign bus.dir_x        = dx_q;
    assign bus.dir_y        = dy_q;
    assign bus.text_visible = vis_q;
    assign bus.corner_hit   = ch_q;
    assign bus.bounce_count = bc_q;
endmodule
